// File: rtl/iopad_dir_sched_if.sv
// Register-file <-> pad-sequencer signal bundle for iopad_dir_sched.
// rf_lock exists only when IOPAD_DIR_LOCK_EN is defined.
interface iopad_dir_sched_if #(
    parameter int NUM_PAD = 2
);
    logic [NUM_PAD-1:0] rf_oen_req;
    logic [NUM_PAD-1:0] rf_ren_req;
    logic [NUM_PAD-1:0] pad_oen;
    logic [NUM_PAD-1:0] pad_ren;
    logic               busy;
    logic [NUM_PAD-1:0] chg_done;
`ifdef IOPAD_DIR_LOCK_EN
    logic               rf_lock;

    modport master (
        output rf_oen_req, rf_ren_req, rf_lock,
        input  pad_oen, pad_ren, busy, chg_done
    );
    modport slave (
        input  rf_oen_req, rf_ren_req, rf_lock,
        output pad_oen, pad_ren, busy, chg_done
    );
`else
    modport master (
        output rf_oen_req, rf_ren_req,
        input  pad_oen, pad_ren, busy, chg_done
    );
    modport slave (
        input  rf_oen_req, rf_ren_req,
        output pad_oen, pad_ren, busy, chg_done
    );
`endif
endinterface

// File: rtl/iopad_dir_sched.sv
// Round-robin pad direction/pull sequencer with a hi-Z, pull-off turnaround window.
// Optional IOPAD_DIR_LOCK_EN: rf_lock holds off new grants while asserted.
module iopad_dir_sched #(
    parameter int NUM_PAD  = 2,
    parameter int TURN_CYC = 4
) (
    input  logic              clk,
    input  logic              rst,
    iopad_dir_sched_if.slave  bus
);
    localparam int PTR_W = (NUM_PAD > 1) ? $clog2(NUM_PAD) : 1;

    typedef enum logic [2:0] {IDLE, SAFE, WAIT, APPLY, DRIVE, DONE} state_t;

    state_t             state, state_nxt;
    logic [PTR_W-1:0]   rr_ptr, gnt, pick;
    logic               pick_vld, grant, lock;
    logic [7:0]         cnt;
    logic               tgt_oen, tgt_ren;
    logic [NUM_PAD-1:0] oen, ren, pend, chg_done;
    logic               busy;
    int                 idx;

`ifdef IOPAD_DIR_LOCK_EN
    assign lock = bus.rf_lock;
`else
    assign lock = 1'b0;
`endif

    assign pend         = (bus.rf_oen_req ^ oen) | (bus.rf_ren_req ^ ren);
    assign bus.pad_oen  = oen;
    assign bus.pad_ren  = ren;
    assign bus.busy     = busy;
    assign bus.chg_done = chg_done;

    // Scan from the highest offset down so the nearest pending pad at/after rr_ptr wins.
    always_comb begin
        pick     = rr_ptr;
        pick_vld = 1'b0;
        idx      = 0;
        for (int i = NUM_PAD - 1; i >= 0; i--) begin
            idx = int'(rr_ptr) + i;
            if (idx >= NUM_PAD) idx = idx - NUM_PAD;
            if (pend[PTR_W'(idx)]) begin
                pick     = PTR_W'(idx);
                pick_vld = 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        grant     = 1'b0;
        case (state)
            IDLE: begin
                if (pick_vld && !lock) begin
                    grant     = 1'b1;
                    state_nxt = SAFE;
                end
            end
            SAFE:    state_nxt = WAIT;
            WAIT:    if (cnt == 8'd0) state_nxt = APPLY;
            APPLY:   state_nxt = tgt_oen ? DONE : DRIVE;
            DRIVE:   state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            cnt      <= '0;
            oen      <= '1;
            ren      <= '1;
            busy     <= 1'b0;
            chg_done <= '0;
        end else begin
            state    <= state_nxt;
            busy     <= (state_nxt != IDLE);
            chg_done <= '0;
            if (state_nxt == DONE) chg_done[gnt] <= 1'b1;
            case (state)
                SAFE: begin
                    oen[gnt] <= 1'b1;
                    ren[gnt] <= 1'b1;
                    cnt      <= 8'(TURN_CYC - 1);
                end
                WAIT: if (cnt != 8'd0) cnt <= cnt - 8'd1;
                // Pull settles first; driving is enabled one cycle later in DRIVE.
                APPLY: begin
                    ren[gnt] <= tgt_ren;
                    if (tgt_oen) oen[gnt] <= 1'b1;
                end
                DRIVE: oen[gnt] <= 1'b0;
                DONE:  rr_ptr <= (int'(gnt) == NUM_PAD - 1) ? '0 : gnt + 1'b1;
                default: ;
            endcase
        end
    end

    // Target is frozen at grant; later request edits are picked up by a new grant.
    always_ff @(posedge clk) begin
        if (grant) begin
            gnt     <= pick;
            tgt_oen <= bus.rf_oen_req[pick];
            tgt_ren <= bus.rf_ren_req[pick];
        end
    end
endmodule

// File: tb/tb_iopad_dir_sched.sv
// Self-checking bench for iopad_dir_sched (NUM_PAD=2, TURN_CYC=4): vector table,
// hand-written corner sequences, and a chg_done scoreboard.
module tb_iopad_dir_sched;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;
    int   done_cnt = 0;
    int   inv_bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    iopad_dir_sched_if #(.NUM_PAD(2)) bus();

    iopad_dir_sched #(.NUM_PAD(2), .TURN_CYC(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int         pad;
        int         cyc;
        logic [1:0] oen;
        logic [1:0] ren;
    } exp_t;

    typedef struct {
        int         pad;
        logic       oen;
        logic       ren;
        int         lat;
        logic [1:0] exp_oen;
        logic [1:0] exp_ren;
    } vec_t;

    exp_t       sb[$];
    exp_t       mon_e;
    vec_t       vecs[7];
    logic [1:0] prev_oen, prev_ren;
    logic       prev_vld = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int pad, input int c, input logic [1:0] o, input logic [1:0] r);
        exp_t e;
        e.pad = pad; e.cyc = c; e.oen = o; e.ren = r;
        sb.push_back(e);
    endtask

    task automatic drain(input int bound);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((sb.size() != 0 || bus.busy) && n < bound);
        check("drain_timeout", 32'(sb.size() != 0 || bus.busy), 32'd0);
    endtask

    // Scoreboard consumer plus pad-safety invariants.
    always @(negedge clk) begin
        if (!rst && bus.chg_done != 2'b00) begin
            done_cnt++;
            if (sb.size() == 0) begin
                check("unexpected_chg_done", 32'(bus.chg_done), 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check("done_pad", 32'(bus.chg_done), 32'd1 << mon_e.pad);
                check("done_cycle", cyc, mon_e.cyc);
                check("done_oen", 32'(bus.pad_oen), 32'(mon_e.oen));
                check("done_ren", 32'(bus.pad_ren), 32'(mon_e.ren));
            end
        end
        if (!rst && prev_vld) begin
            if ($countones((bus.pad_oen ^ prev_oen) | (bus.pad_ren ^ prev_ren)) > 1) inv_bad++;
            if ((~bus.pad_oen & ~bus.pad_ren) != 2'b00) inv_bad++;
        end
        prev_oen = bus.pad_oen;
        prev_ren = bus.pad_ren;
        prev_vld = !rst;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  n;
        logic win_ok;

        vecs[0] = '{0, 1'b0, 1'b1, 8, 2'b10, 2'b11};
        vecs[1] = '{1, 1'b0, 1'b1, 8, 2'b00, 2'b11};
        vecs[2] = '{1, 1'b1, 1'b0, 7, 2'b10, 2'b01};
        vecs[3] = '{1, 1'b1, 1'b1, 7, 2'b10, 2'b11};
        vecs[4] = '{0, 1'b1, 1'b0, 7, 2'b11, 2'b10};
        vecs[5] = '{0, 1'b0, 1'b1, 8, 2'b10, 2'b11};
        vecs[6] = '{1, 1'b1, 1'b0, 7, 2'b10, 2'b01};

        bus.rf_oen_req = 2'b11;
        bus.rf_ren_req = 2'b11;
`ifdef IOPAD_DIR_LOCK_EN
        bus.rf_lock = 1'b0;
`endif
        repeat (3) @(negedge clk);
        check("reset_oen", 32'(bus.pad_oen), 32'h3);
        check("reset_ren", 32'(bus.pad_ren), 32'h3);
        check("reset_busy", 32'(bus.busy), 32'd0);
        check("reset_done", 32'(bus.chg_done), 32'd0);
        rst = 1'b0;

        // Single-pad changes from the table; hi-Z window checked around each grant.
        for (int v = 0; v < 7; v++) begin
            @(negedge clk);
            bus.rf_oen_req[vecs[v].pad] = vecs[v].oen;
            bus.rf_ren_req[vecs[v].pad] = vecs[v].ren;
            n = cyc;
            push(vecs[v].pad, n + vecs[v].lat, vecs[v].exp_oen, vecs[v].exp_ren);
            win_ok = 1'b1;
            for (int k = 1; k <= vecs[v].lat; k++) begin
                @(negedge clk);
                if (k >= 2 && k <= 7 && bus.pad_oen[vecs[v].pad] !== 1'b1) win_ok = 1'b0;
                if (k >= 2 && k <= 6 && bus.pad_ren[vecs[v].pad] !== 1'b1) win_ok = 1'b0;
            end
            check("hiz_window", 32'(win_ok), 32'd1);
            drain(40);
        end

        // Tie with rr_ptr=0: pad0 first, then pad1.
        @(negedge clk);
        bus.rf_oen_req = 2'b01;
        bus.rf_ren_req = 2'b10;
        n = cyc;
        push(0, n + 7, 2'b11, 2'b00);
        push(1, n + 16, 2'b01, 2'b10);
        drain(40);

        // Service pad0 alone so rr_ptr moves to 1.
        @(negedge clk);
        bus.rf_oen_req = 2'b00;
        bus.rf_ren_req = 2'b11;
        n = cyc;
        push(0, n + 8, 2'b00, 2'b11);
        drain(40);

        // Tie with rr_ptr=1: pad1 first, then pad0.
        @(negedge clk);
        bus.rf_oen_req = 2'b11;
        bus.rf_ren_req = 2'b00;
        n = cyc;
        push(1, n + 7, 2'b10, 2'b01);
        push(0, n + 15, 2'b11, 2'b00);
        drain(40);

        // Request flipped back during WAIT: latched target first, then a restoring sequence.
        @(negedge clk);
        bus.rf_oen_req = 2'b10;
        bus.rf_ren_req = 2'b01;
        n = cyc;
        push(0, n + 8, 2'b10, 2'b01);
        repeat (3) @(negedge clk);
        bus.rf_oen_req[0] = 1'b1;
        push(0, n + 16, 2'b11, 2'b01);
        drain(40);

`ifdef IOPAD_DIR_LOCK_EN
        @(negedge clk);
        bus.rf_lock = 1'b1;
        bus.rf_ren_req[1] = 1'b1;
        bus.rf_oen_req[0] = 1'b0;
        @(negedge clk);
        bus.rf_oen_req[0] = 1'b1;
        repeat (4) @(negedge clk);
        check("lock_busy", 32'(bus.busy), 32'd0);
        check("lock_ren_hold", 32'(bus.pad_ren), 32'h1);
        check("lock_oen_hold", 32'(bus.pad_oen), 32'h3);
        bus.rf_lock = 1'b0;
        n = cyc;
        push(1, n + 7, 2'b11, 2'b11);
        @(negedge clk);
        check("unlock_busy", 32'(bus.busy), 32'd1);
        drain(40);
`endif

        // Put pad1 into drive so an asynchronous reset has something to undo.
        @(negedge clk);
        bus.rf_oen_req = 2'b01;
        bus.rf_ren_req = 2'b11;
        n = cyc;
        push(1, n + 8, 2'b01, 2'b11);
        drain(40);

        @(negedge clk);
        bus.rf_oen_req = 2'b00;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("async_rst_oen", 32'(bus.pad_oen), 32'h3);
        check("async_rst_ren", 32'(bus.pad_ren), 32'h3);
        check("async_rst_busy", 32'(bus.busy), 32'd0);
        bus.rf_oen_req = 2'b11;
        bus.rf_ren_req = 2'b11;
        n = done_cnt;
        @(negedge clk);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        check("post_rst_no_done", done_cnt, n);
        check("post_rst_busy", 32'(bus.busy), 32'd0);
        check("post_rst_oen", 32'(bus.pad_oen), 32'h3);

        check("sb_empty", sb.size(), 0);
        check("pad_safety", inv_bad, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
